// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-outstanding icache requests, a small instruction
// queue with op-type pre-classification, and flush/redirect handling.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IQ_DEPTH = 4,
    parameter int          IQ_AW    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    input  logic        dc_stall,
    output logic        if_to_dc_ready,
    output logic [31:0] if_to_dc_PC,
    output logic [31:0] if_to_dc_inst,
    output logic [3:0]  if_to_dc_opType
);

    localparam logic [IQ_AW:0]   DEPTH_C = (IQ_AW + 1)'(IQ_DEPTH);
    localparam logic [IQ_AW:0]   CNT_ONE = 1;
    localparam logic [IQ_AW-1:0] PTR_ONE = 1;

    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic             drop;
    logic [IQ_AW-1:0] head;
    logic [IQ_AW-1:0] tail;
    logic [IQ_AW:0]   count;

    logic [31:0] q_pc   [IQ_DEPTH];
    logic [31:0] q_inst [IQ_DEPTH];
    logic [3:0]  q_op   [IQ_DEPTH];

    logic do_issue;
    logic resp_take;
    logic do_push;
    logic do_pop;

    function automatic logic [3:0] classify(input logic [6:0] opc);
        case (opc)
            7'b0110011: classify = 4'd0;
            7'b0010011: classify = 4'd1;
            7'b0000011: classify = 4'd2;
            7'b0100011: classify = 4'd3;
            7'b1100011: classify = 4'd4;
            7'b1101111: classify = 4'd5;
            7'b1100111: classify = 4'd6;
            7'b0110111: classify = 4'd7;
            7'b0010111: classify = 4'd8;
            default:    classify = 4'd15;
        endcase
    endfunction

    // Handshake: the decoder takes the head in any cycle where ready is high
    // and it is not stalling; rdy_in low freezes the pop as well.
    assign if_to_dc_ready  = (count != '0) & ~flush_in;
    assign if_to_dc_PC     = q_pc[head];
    assign if_to_dc_inst   = q_inst[head];
    assign if_to_dc_opType = q_op[head];

    // Requests only go out with no response pending, so a full queue can never be overrun.
    assign do_issue  = rdy_in & ~flush_in & ~inflight & (count < DEPTH_C);
    assign resp_take = ic_resp_valid & inflight;
    assign do_push   = resp_take & ~drop & ~flush_in;
    assign do_pop    = if_to_dc_ready & ~dc_stall & rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc           <= RESET_PC;
            req_pc       <= '0;
            inflight     <= 1'b0;
            drop         <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ic_req_valid <= 1'b0;
            ic_req_addr  <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
                q_op[i]   <= '0;
            end
        end else begin
            ic_req_valid <= do_issue;
            if (flush_in) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                pc       <= flush_pc;
                // A request still outstanding after this cycle must have its data discarded.
                inflight <= inflight & ~ic_resp_valid;
                drop     <= inflight & ~ic_resp_valid;
            end else begin
                if (do_issue) begin
                    ic_req_addr <= pc;
                    req_pc      <= pc;
                    pc          <= pc + 32'd4;
                    inflight    <= 1'b1;
                end else if (resp_take) begin
                    inflight <= 1'b0;
                    drop     <= 1'b0;
                end
                if (do_push) begin
                    q_pc[tail]   <= req_pc;
                    q_inst[tail] <= ic_resp_inst;
                    q_op[tail]   <= classify(ic_resp_inst[6:0]);
                    tail         <= tail + PTR_ONE;
                end
                if (do_pop) begin
                    head <= head + PTR_ONE;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-programmable icache model.
module tb_inst_fetch;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_inst;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        dc_stall;
    logic        if_to_dc_ready;
    logic [31:0] if_to_dc_PC;
    logic [31:0] if_to_dc_inst;
    logic [3:0]  if_to_dc_opType;

    int checks;
    int errors;
    int cyc;

    int          lat;
    logic        sweep_mode;
    logic [31:0] inst_base;
    logic [31:0] sweep_tbl [4];
    logic [31:0] exp_q [$];

    logic        pend;
    int          wait_cnt;
    logic [31:0] paddr;

    inst_fetch dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_inst    (ic_resp_inst),
        .flush_in        (flush_in),
        .flush_pc        (flush_pc),
        .dc_stall        (dc_stall),
        .if_to_dc_ready  (if_to_dc_ready),
        .if_to_dc_PC     (if_to_dc_PC),
        .if_to_dc_inst   (if_to_dc_inst),
        .if_to_dc_opType (if_to_dc_opType)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (sweep_mode) return sweep_tbl[a[3:2]];
        return inst_base ^ {a[24:0], 7'b0};
    endfunction

    // icache model: a request seen in cycle r is answered in cycle r+lat
    always @(negedge clk_in) begin
        ic_resp_valid = 1'b0;
        if (pend) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                ic_resp_valid = 1'b1;
                ic_resp_inst  = mem_word(paddr);
                pend          = 1'b0;
            end
        end
        if (ic_req_valid) begin
            pend     = 1'b1;
            wait_cnt = lat;
            paddr    = ic_req_addr;
        end
    end

    task automatic adv();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int lat_i, input logic sweep_i);
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        flush_in   = 1'b0;
        flush_pc   = '0;
        dc_stall   = 1'b1;
        lat        = lat_i;
        sweep_mode = sweep_i;
        repeat (4) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_reset();
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        flush_pc = '0;
        dc_stall = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0h exp 0", ic_req_valid); end
        checks++; if (ic_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h exp 0", ic_req_addr); end
        checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0h exp 0", if_to_dc_ready); end
        checks++; if (if_to_dc_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_to_dc_PC); end
        checks++; if (if_to_dc_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", if_to_dc_inst); end
        checks++; if (if_to_dc_opType !== 4'h0) begin errors++; $display("FAIL reset_optype got %0h exp 0", if_to_dc_opType); end
    endtask

    task automatic test_first_fetch();
        inst_base = 32'h00A00093;
        do_reset(2, 1'b0);
        @(negedge clk_in);
        checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL ff_c0_req got %0h exp 0", ic_req_valid); end
        adv();
        @(negedge clk_in);
        checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0) begin errors++; $display("FAIL ff_c1_req got %0h/%h exp 1/0", ic_req_valid, ic_req_addr); end
        adv(); adv();
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL ff_c3_ready got %0h exp 0", if_to_dc_ready); end
        adv();
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b1) begin errors++; $display("FAIL ff_c4_ready got %0h exp 1", if_to_dc_ready); end
        checks++; if (if_to_dc_PC !== 32'h0) begin errors++; $display("FAIL ff_c4_pc got %h exp 0", if_to_dc_PC); end
        checks++; if (if_to_dc_inst !== 32'h00A00093) begin errors++; $display("FAIL ff_c4_inst got %h exp 00a00093", if_to_dc_inst); end
        checks++; if (if_to_dc_opType !== 4'd1) begin errors++; $display("FAIL ff_c4_optype got %0d exp 1", if_to_dc_opType); end
        adv();
        @(negedge clk_in);
        checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h4) begin errors++; $display("FAIL ff_c5_req got %0h/%h exp 1/4", ic_req_valid, ic_req_addr); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] seen [$];
        logic [31:0] e;
        inst_base = 32'h00000033;
        do_reset(1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (ic_req_valid) seen.push_back(ic_req_addr);
            adv();
        end
        checks++; if (seen.size() !== 4) begin errors++; $display("FAIL fill_req_count got %0d exp 4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++; if (seen[i] !== 32'(i * 4)) begin errors++; $display("FAIL fill_req_addr%0d got %h exp %h", i, seen[i], 32'(i * 4)); end
        end
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        dc_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            e = exp_q.pop_front();
            checks++; if (if_to_dc_ready !== 1'b1 || if_to_dc_PC !== e) begin errors++; $display("FAIL drain%0d got %0h/%h exp 1/%h", k, if_to_dc_ready, if_to_dc_PC, e); end
            checks++; if (if_to_dc_inst !== mem_word(e)) begin errors++; $display("FAIL drain_inst%0d got %h exp %h", k, if_to_dc_inst, mem_word(e)); end
            checks++; if (ic_req_valid !== (k == 2)) begin errors++; $display("FAIL drain_req%0d got %0h exp %0h", k, ic_req_valid, (k == 2)); end
            if (k == 2) begin
                checks++; if (ic_req_addr !== 32'h10) begin errors++; $display("FAIL resume_addr got %h exp 10", ic_req_addr); end
            end
            adv();
        end
    endtask

    task automatic test_flush_inflight();
        inst_base = 32'h00002003;
        do_reset(2, 1'b0);
        repeat (9) adv();
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b1) begin errors++; $display("FAIL fl_pre_ready got %0h exp 1", if_to_dc_ready); end
        adv();
        flush_in = 1'b1;
        flush_pc = 32'h200;
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL fl_cyc_ready got %0h exp 0", if_to_dc_ready); end
        adv();
        flush_in = 1'b0;
        while (cyc <= 15) begin
            @(negedge clk_in);
            checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL fl_ready_c%0d got %0h exp 0", cyc, if_to_dc_ready); end
            checks++; if (ic_req_valid !== (cyc == 13)) begin errors++; $display("FAIL fl_req_c%0d got %0h exp %0h", cyc, ic_req_valid, (cyc == 13)); end
            if (cyc == 13) begin
                checks++; if (ic_req_addr !== 32'h200) begin errors++; $display("FAIL fl_req_addr got %h exp 200", ic_req_addr); end
            end
            adv();
        end
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b1 || if_to_dc_PC !== 32'h200) begin errors++; $display("FAIL fl_head got %0h/%h exp 1/200", if_to_dc_ready, if_to_dc_PC); end
        checks++; if (if_to_dc_inst !== mem_word(32'h200) || if_to_dc_opType !== 4'd2) begin errors++; $display("FAIL fl_head_data got %h/%0d exp %h/2", if_to_dc_inst, if_to_dc_opType, mem_word(32'h200)); end
    endtask

    task automatic test_flush_with_resp();
        inst_base = 32'h00000063;
        do_reset(2, 1'b0);
        repeat (7) adv();
        flush_in = 1'b1;
        flush_pc = 32'h300;
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL fr_cyc_ready got %0h exp 0", if_to_dc_ready); end
        adv();
        flush_in = 1'b0;
        while (cyc <= 11) begin
            @(negedge clk_in);
            checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL fr_ready_c%0d got %0h exp 0", cyc, if_to_dc_ready); end
            checks++; if (ic_req_valid !== (cyc == 9)) begin errors++; $display("FAIL fr_req_c%0d got %0h exp %0h", cyc, ic_req_valid, (cyc == 9)); end
            if (cyc == 9) begin
                checks++; if (ic_req_addr !== 32'h300) begin errors++; $display("FAIL fr_req_addr got %h exp 300", ic_req_addr); end
            end
            adv();
        end
        dc_stall = 1'b0;
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b1 || if_to_dc_PC !== 32'h300 || if_to_dc_opType !== 4'd4) begin errors++; $display("FAIL fr_head got %0h/%h/%0d exp 1/300/4", if_to_dc_ready, if_to_dc_PC, if_to_dc_opType); end
        adv();
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL fr_stale got %0h exp 0", if_to_dc_ready); end
    endtask

    task automatic test_opcode_sweep();
        logic [3:0] exp_op [4];
        exp_op = '{4'd5, 4'd6, 4'd7, 4'd15};
        do_reset(1, 1'b1);
        repeat (15) adv();
        dc_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            checks++; if (if_to_dc_ready !== 1'b1 || if_to_dc_opType !== exp_op[k]) begin errors++; $display("FAIL sweep_op%0d got %0h/%0d exp 1/%0d", k, if_to_dc_ready, if_to_dc_opType, exp_op[k]); end
            checks++; if (if_to_dc_inst !== sweep_tbl[k]) begin errors++; $display("FAIL sweep_inst%0d got %h exp %h", k, if_to_dc_inst, sweep_tbl[k]); end
            adv();
        end
    endtask

    task automatic test_pause();
        int pops;
        int reqs;
        logic [31:0] e;
        inst_base = 32'h00000017;
        do_reset(1, 1'b0);
        dc_stall = 1'b0;
        pops = 0;
        reqs = 0;
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        while (cyc < 20) begin
            rdy_in = !(cyc >= 8 && cyc <= 10);
            @(negedge clk_in);
            if (ic_req_valid) reqs++;
            if (cyc >= 8 && cyc <= 11) begin
                checks++; if (ic_req_valid !== 1'b0) begin errors++; $display("FAIL pause_req_c%0d got %0h exp 0", cyc, ic_req_valid); end
            end
            if (cyc == 10) begin
                checks++; if (if_to_dc_ready !== 1'b1 || if_to_dc_PC !== 32'h8) begin errors++; $display("FAIL pause_capture got %0h/%h exp 1/8", if_to_dc_ready, if_to_dc_PC); end
            end
            if (if_to_dc_ready && !dc_stall && rdy_in) begin
                pops++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                checks++; if (if_to_dc_PC !== e || if_to_dc_inst !== mem_word(e) || if_to_dc_opType !== 4'd8) begin errors++; $display("FAIL pause_pop%0d got %h/%h/%0d exp %h/%h/8", pops, if_to_dc_PC, if_to_dc_inst, if_to_dc_opType, e, mem_word(e)); end
            end
            adv();
        end
        rdy_in = 1'b1;
        checks++; if (pops !== 5) begin errors++; $display("FAIL pause_pops got %0d exp 5", pops); end
        checks++; if (reqs !== 6) begin errors++; $display("FAIL pause_reqs got %0d exp 6", reqs); end
    endtask

    task automatic test_async_reset();
        inst_base = 32'h00A00093;
        do_reset(2, 1'b0);
        repeat (6) adv();
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b1 || ic_req_addr !== 32'h4) begin errors++; $display("FAIL ar_pre got %0h/%h exp 1/4", if_to_dc_ready, ic_req_addr); end
        #1;
        rst_in = 1'b0;
        #1;
        checks++; if (ic_req_valid !== 1'b0 || ic_req_addr !== 32'h0 || if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL ar_ctl got %0h/%h/%0h exp 0/0/0", ic_req_valid, ic_req_addr, if_to_dc_ready); end
        checks++; if (if_to_dc_PC !== 32'h0 || if_to_dc_inst !== 32'h0 || if_to_dc_opType !== 4'h0) begin errors++; $display("FAIL ar_data got %h/%h/%0h exp 0/0/0", if_to_dc_PC, if_to_dc_inst, if_to_dc_opType); end
        adv();
        rst_in = 1'b1;
        cyc = 7;
        while (cyc <= 10) begin
            @(negedge clk_in);
            checks++; if (if_to_dc_ready !== 1'b0) begin errors++; $display("FAIL ar_stray_c%0d got %0h exp 0", cyc, if_to_dc_ready); end
            if (cyc == 8) begin
                checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0) begin errors++; $display("FAIL ar_req got %0h/%h exp 1/0", ic_req_valid, ic_req_addr); end
            end
            adv();
        end
        @(negedge clk_in);
        checks++; if (if_to_dc_ready !== 1'b1 || if_to_dc_PC !== 32'h0 || if_to_dc_inst !== 32'h00A00093) begin errors++; $display("FAIL ar_head got %0h/%h/%h exp 1/0/00a00093", if_to_dc_ready, if_to_dc_PC, if_to_dc_inst); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        flush_in   = 1'b0;
        flush_pc   = '0;
        dc_stall   = 1'b0;
        lat        = 1;
        sweep_mode = 1'b0;
        inst_base  = '0;
        pend       = 1'b0;
        wait_cnt   = 0;
        paddr      = '0;
        ic_resp_valid = 1'b0;
        ic_resp_inst  = '0;
        sweep_tbl  = '{32'h0000006F, 32'h00008067, 32'h12345037, 32'hFFFFFFFF};

        test_reset();
        test_first_fetch();
        test_fill_stall();
        test_flush_inflight();
        test_flush_with_resp();
        test_opcode_sweep();
        test_pause();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
